// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the execute stage and the multi-cycle mul/div unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
    logic            start_i;
    logic [2:0]      fun3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      wd_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_req_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      wd_o;
    logic            wreg_o;
    modport master (output start_i, fun3_i, op1_i, op2_i, wd_i, flush_i,
                    input busy_o, stall_req_o, done_o, result_o, wd_o, wreg_o);
    modport slave (input start_i, fun3_i, op1_i, op2_i, wd_i, flush_i,
                   output busy_o, stall_req_o, done_o, result_o, wd_o, wreg_o);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M/RV64M unit with iterative shift-add multiply and restoring divide.
// Works on magnitudes; sign is reapplied in FIX. Special cases skip straight to DONE.
module ex_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 1
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        wd_q, wd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              is_div, sgn1, sgn2, div0, ovf, fast, accept;
    logic [XLEN-1:0]   abs1, abs2, spec_res, quo, rem;
    logic [2*XLEN-1:0] fprod, fprod_s, mprod;
    logic [XLEN:0]     msum, dtrial;
    assign is_div   = bus.fun3_i[2];
    assign sgn1     = bus.op1_i[XLEN-1] & (is_div ? ~bus.fun3_i[0] : bus.fun3_i[1] ^ bus.fun3_i[0]);
    assign sgn2     = bus.op2_i[XLEN-1] & (is_div ? ~bus.fun3_i[0] : bus.fun3_i[1:0] == 2'b01);
    assign abs1     = sgn1 ? -bus.op1_i : bus.op1_i;
    assign abs2     = sgn2 ? -bus.op2_i : bus.op2_i;
    assign div0     = is_div & ~|bus.op2_i;
    assign ovf      = is_div & ~bus.fun3_i[0] & (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op2_i);
    assign fast     = div0 | ovf | (~is_div & (MUL_ITER == 0));
    assign fprod    = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
    assign fprod_s  = (sgn1 ^ sgn2) ? -fprod : fprod;
    assign spec_res = div0 ? (bus.fun3_i[1] ? bus.op1_i : '1) :
                      ovf  ? (bus.fun3_i[1] ? '0 : bus.op1_i) :
                      (bus.fun3_i[1:0] == 2'b00 ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN]);
    assign accept   = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign dtrial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign mprod    = neg_q ? -acc_q : acc_q;
    assign quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem      = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            neg_q   <= 1'b0;
            b_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            neg_q   <= neg_d;
            b_q     <= b_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
        end
    end
    always_comb begin
        state_d = bus.flush_i          ? IDLE :
                  (state_q == IDLE)    ? (accept ? (fast ? DONE : CALC) : IDLE) :
                  (state_q == CALC)    ? (cnt_q == CW'(1) ? FIX : CALC) :
                  (state_q == FIX)     ? DONE : IDLE;
    end
    always_comb begin
        cnt_d = cnt_q;
        f3_d  = f3_q;
        wd_d  = wd_q;
        neg_d = neg_q;
        b_d   = b_q;
        acc_d = acc_q;
        res_d = res_q;
        if (accept) begin
            f3_d  = bus.fun3_i;
            wd_d  = bus.wd_i;
            neg_d = (is_div & bus.fun3_i[1]) ? sgn1 : sgn1 ^ sgn2;
            cnt_d = CW'(XLEN);
            b_d   = is_div ? abs2 : abs1;
            acc_d = {{XLEN{1'b0}}, is_div ? abs1 : abs2};
            res_d = spec_res;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q - 1'b1;
            acc_d = f3_q[2] ? (dtrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                            : {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                            : {msum, acc_q[XLEN-1:1]};
        end else if (state_q == FIX) begin
            res_d = f3_q[2] ? (f3_q[1] ? rem : quo)
                            : (f3_q[1:0] == 2'b00 ? mprod[XLEN-1:0] : mprod[2*XLEN-1:XLEN]);
        end
    end
    always_comb begin
        bus.busy_o      = state_q != IDLE;
        bus.stall_req_o = ((state_q == IDLE) & bus.start_i & ~bus.flush_i & ~rst) | (state_q == CALC) | (state_q == FIX);
        bus.done_o      = state_q == DONE;
        bus.result_o    = bus.done_o ? res_q : '0;
        bus.wd_o        = bus.done_o ? wd_q : '0;
        bus.wreg_o      = bus.done_o & (|wd_q);
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed tests of ex_muldiv (XLEN=32, iterative multiply).
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    ex_muldiv_if #(.XLEN(32)) bus();
    ex_muldiv #(.XLEN(32), .MUL_ITER(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          l;
    } vec_t;
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, output logic [31:0] res, output int lat,
                         output logic [4:0] wdo, output logic wr, output logic stall_ok);
        bus.start_i = 1'b1;
        bus.fun3_i  = f3;
        bus.op1_i   = a;
        bus.op2_i   = b;
        bus.wd_i    = wd;
        #1;
        stall_ok = (bus.stall_req_o === 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            bus.start_i = 1'b0;
            lat++;
            #1;
            if (bus.done_o !== 1'b1 && bus.stall_req_o !== 1'b1) stall_ok = 1'b0;
        end while (bus.done_o !== 1'b1 && lat < 60);
        if (bus.stall_req_o !== 1'b0) stall_ok = 1'b0;
        res = bus.result_o;
        wdo = bus.wd_o;
        wr  = bus.wreg_o;
    endtask
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b1;
        #1;
        n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", bus.stall_req_o); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", bus.done_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_err++; $display("FAIL rst_result got %h want 0", bus.result_o); end
        n_cmp++; if (bus.wd_o !== 5'h0 || bus.wreg_o !== 1'b0) begin n_err++; $display("FAIL rst_wd got %h/%b want 0/0", bus.wd_o, bus.wreg_o); end
        bus.start_i = 1'b0;
        rst = 1'b0;
    endtask
    task automatic run_table(input string tag, input vec_t v[6]);
        logic [31:0] r;
        logic [4:0]  w;
        logic        wr, st;
        int          l;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            do_op(v[i].f, v[i].a, v[i].b, 5'(i + 1), r, l, w, wr, st);
            n_cmp++; if (r !== v[i].e) begin n_err++; $display("FAIL %s[%0d]_result got %h want %h", tag, i, r, v[i].e); end
            n_cmp++; if (l !== v[i].l) begin n_err++; $display("FAIL %s[%0d]_latency got %0d want %0d", tag, i, l, v[i].l); end
            n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL %s[%0d]_stall got %b want 1", tag, i, st); end
            n_cmp++; if (w !== 5'(i + 1) || wr !== 1'b1) begin n_err++; $display("FAIL %s[%0d]_wd got %h/%b want %h/1", tag, i, w, wr, 5'(i + 1)); end
        end
    endtask
    task automatic test_mul();
        vec_t v[6];
        v[0] = '{3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        v[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        v[2] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
        v[3] = '{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34};
        v[4] = '{3'b000, 32'h12345678, 32'h10, 32'h23456780, 34};
        v[5] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        run_table("mul", v);
    endtask
    task automatic test_div();
        vec_t v[6];
        v[0] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34};
        v[1] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34};
        v[2] = '{3'b101, 32'd100, 32'd7, 32'd14, 34};
        v[3] = '{3'b111, 32'd100, 32'd7, 32'd2, 34};
        v[4] = '{3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34};
        v[5] = '{3'b110, 32'd100, 32'hFFFFFFF9, 32'd2, 34};
        run_table("div", v);
    endtask
    task automatic test_special();
        vec_t v[6];
        v[0] = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
        v[1] = '{3'b110, 32'd5, 32'd0, 32'd5, 1};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
        v[4] = '{3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, 1};
        v[5] = '{3'b111, 32'd9, 32'd0, 32'd9, 1};
        run_table("special", v);
    endtask
    task automatic test_flush();
        logic [31:0] r;
        logic [4:0]  w;
        logic        wr, st, seen;
        int          l;
        @(negedge clk);
        bus.start_i = 1'b1; bus.fun3_i = 3'b100; bus.op1_i = 32'd1000; bus.op2_i = 32'd3; bus.wd_i = 5'd9;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (c == 10) bus.flush_i = 1'b1;
            #1;
            seen |= bus.done_o;
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0 || seen || bus.done_o !== 1'b0) begin n_err++; $display("FAIL flush_abort busy=%b done_seen=%b want 0/0", bus.busy_o, seen | bus.done_o); end
        do_op(3'b000, 32'd3, 32'd4, 5'd2, r, l, w, wr, st);
        n_cmp++; if (r !== 32'd12) begin n_err++; $display("FAIL flush_next_result got %h want %h", r, 32'd12); end
        n_cmp++; if (l !== 34) begin n_err++; $display("FAIL flush_next_latency got %0d want 34", l); end
        @(negedge clk);
        bus.start_i = 1'b1; bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL flush_start_stall got %b want 0", bus.stall_req_o); end
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got %b want 0", bus.busy_o); end
    endtask
    task automatic test_hold();
        int dones = 0;
        int first = 0;
        logic [31:0] r = '0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.fun3_i = 3'b000; bus.op1_i = 32'd5; bus.op2_i = 32'd6; bus.wd_i = 5'd4;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.op1_i = 32'(c * 3 + 11);
            bus.op2_i = 32'(c + 100);
            #1;
            if (bus.done_o === 1'b1) begin
                dones++;
                if (dones == 1) begin first = c; r = bus.result_o; end
                bus.start_i = 1'b0;
            end
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL hold_pulses got %0d want 1", dones); end
        n_cmp++; if (r !== 32'd30) begin n_err++; $display("FAIL hold_result got %h want %h", r, 32'd30); end
        n_cmp++; if (first !== 34) begin n_err++; $display("FAIL hold_latency got %0d want 34", first); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL hold_idle busy got %b want 0", bus.busy_o); end
    endtask
    task automatic test_wd_zero();
        logic [31:0] r;
        logic [4:0]  w;
        logic        wr, st;
        int          l;
        @(negedge clk);
        do_op(3'b000, 32'd2, 32'd2, 5'd0, r, l, w, wr, st);
        n_cmp++; if (l !== 34 || r !== 32'd4) begin n_err++; $display("FAIL wd0_done lat=%0d res=%h want 34/%h", l, r, 32'd4); end
        n_cmp++; if (wr !== 1'b0 || w !== 5'd0) begin n_err++; $display("FAIL wd0_wreg got %b/%h want 0/0", wr, w); end
    endtask
    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        logic [4:0]  w;
        logic        wr, st;
        int          l1, l2;
        @(negedge clk);
        do_op(3'b101, 32'd100, 32'd7, 5'd7, r1, l1, w, wr, st);
        @(negedge clk);
        do_op(3'b111, 32'd100, 32'd7, 5'd8, r2, l2, w, wr, st);
        n_cmp++; if (r1 !== 32'd14 || l1 !== 34) begin n_err++; $display("FAIL b2b_first got %h/%0d want %h/34", r1, l1, 32'd14); end
        n_cmp++; if (r2 !== 32'd2 || l2 !== 34 || w !== 5'd8) begin n_err++; $display("FAIL b2b_second got %h/%0d/%h want %h/34/08", r2, l2, w, 32'd2); end
    endtask
    task automatic test_rst_mid();
        logic seen = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.fun3_i = 3'b101; bus.op1_i = 32'd50; bus.op2_i = 32'd5; bus.wd_i = 5'd3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.stall_req_o !== 1'b0 || bus.done_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl busy/stall/done got %b%b%b want 000", bus.busy_o, bus.stall_req_o, bus.done_o); end
        n_cmp++; if (bus.result_o !== 32'h0 || bus.wd_o !== 5'h0 || bus.wreg_o !== 1'b0) begin n_err++; $display("FAIL rstmid_data got %h/%h/%b want 0", bus.result_o, bus.wd_o, bus.wreg_o); end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            seen |= bus.done_o;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done got %b want 0", seen); end
    endtask
    initial begin
        bus.start_i = 1'b0; bus.fun3_i = '0; bus.op1_i = '0; bus.op2_i = '0; bus.wd_i = '0; bus.flush_i = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_hold();
        test_wd_zero();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d compared", n_cmp);
        $fatal(1);
    end
endmodule
